// File: rtl/fp_mac_status_pipe.sv
// Sideband pipeline for the FP MAC: carries sign, exception flags and tag through DEPTH stages
// with valid/ready backpressure, bubble collapsing, synchronous flush and sticky flag capture.
module fp_mac_status_pipe #(
    parameter  int DEPTH = 4,
    parameter  int FLAGW = 5,
    parameter  int TAGW  = 4,
    localparam int OCCW  = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [FLAGW-1:0] in_flags,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [FLAGW-1:0] out_flags,
    output logic [TAGW-1:0]  out_tag,
    output logic [FLAGW-1:0] sticky_flags,
    input  logic             sticky_clr,
    output logic [OCCW-1:0]  occupancy
);

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] adv;
    logic             adv_chain;
    logic             sign_q  [DEPTH];
    logic [FLAGW-1:0] flags_q [DEPTH];
    logic [TAGW-1:0]  tag_q   [DEPTH];
    logic             hs;

    // A stage moves when it is empty or everything downstream moves; empty stages always accept.
    always_comb begin
        adv          = '0;
        adv_chain    = !vld[DEPTH-1] | out_ready;
        adv[DEPTH-1] = adv_chain;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv_chain = !vld[i] | adv_chain;
            adv[i]    = adv_chain;
        end
    end

    assign in_ready  = adv[0] & !flush;
    assign out_valid = vld[DEPTH-1] & !flush;
    assign hs        = out_valid & out_ready;
    assign out_sign  = sign_q[DEPTH-1];
    assign out_flags = flags_q[DEPTH-1];
    assign out_tag   = tag_q[DEPTH-1];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            vld <= '0;
        end else if (flush) begin
            vld <= '0;
        end else begin
            if (adv[0]) vld[0] <= in_valid & in_ready;
            for (int i = 1; i < DEPTH; i++) begin
                if (adv[i]) vld[i] <= vld[i-1];
            end
        end
    end

    // Payload registers hold their contents across a flush; only the valid bits are dropped.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                sign_q[i]  <= 1'b0;
                flags_q[i] <= '0;
                tag_q[i]   <= '0;
            end
        end else if (!flush) begin
            if (adv[0]) begin
                sign_q[0]  <= in_sign;
                flags_q[0] <= in_flags;
                tag_q[0]   <= in_tag;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (adv[i]) begin
                    sign_q[i]  <= sign_q[i-1];
                    flags_q[i] <= flags_q[i-1];
                    tag_q[i]   <= tag_q[i-1];
                end
            end
        end
    end

    // A beat handed off in the same cycle as a clear survives the clear.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sticky_flags <= '0;
        end else begin
            sticky_flags <= (sticky_clr ? '0 : sticky_flags) | (hs ? out_flags : '0);
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCCW'(vld[i]);
        end
    end

endmodule
